jstk2_spi_sequencer: RTL and testbench
======================================

JSTK2_SPI_SEQUENCER -- requirements
Module: jstk2_spi_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100, giving i_clk cycles per SCLK half-period (500 kHz at 100 MHz).
REQ-002 The block SHALL have parameter CS_SETUP_CYC, default 1500, giving i_clk cycles from CS falling to the first SCLK edge.
REQ-003 The block SHALL have parameter BYTE_GAP_CYC, default 1000, giving i_clk cycles of idle SCLK between bytes.
REQ-004 The block SHALL have parameter CS_HOLD_CYC, default 100, giving i_clk cycles from the last SCLK falling edge to CS rising.
REQ-005 The block SHALL have port i_clk, input, 1 bit: the single system clock.
REQ-006 The block SHALL have port i_n_reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port i_start, input, 1 bit: transaction request.
REQ-008 The block SHALL have port i_cmd, input, 8 bits: command byte (byte 0 on MOSI).
REQ-009 The block SHALL have port i_param, input, 32 bits: parameter bytes 1..4, with [31:24] sent first.
REQ-010 The block SHALL have port i_miso, input, 1 bit: serial data from the joystick.
REQ-011 The block SHALL have port o_sclk, output, 1 bit: SPI clock, mode 0.
REQ-012 The block SHALL have port o_mosi, output, 1 bit: serial data to the joystick.
REQ-013 The block SHALL have port o_cs, output, 1 bit: active-low chip select.
REQ-014 The block SHALL have port o_busy, output, 1 bit: a transaction is in progress.
REQ-015 The block SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have ports o_x and o_y, output, 10 bits each: joystick position.
REQ-017 The block SHALL have port o_btn, output, 2 bits: {trigger, joystick button}.

Function
REQ-018 The FSM SHALL use states IDLE, CS_SETUP, SHIFT, BYTE_GAP, CS_HOLD and DONE.
REQ-019 In IDLE, i_start=1 SHALL latch i_cmd and i_param, and on the next cycle enter CS_SETUP with o_cs=0 and o_busy=1.
REQ-020 i_start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-021 CS_SETUP SHALL last exactly CS_SETUP_CYC cycles with o_sclk=0 and o_mosi = MSB of byte 0, then enter SHIFT.
REQ-022 SHIFT SHALL send 8 bits MSB-first; each bit is CLK_DIV cycles of SCLK low followed by CLK_DIV cycles of SCLK high.
REQ-023 o_mosi SHALL change only at the start of a low phase; i_miso SHALL be sampled on the cycle o_sclk rises.
REQ-024 A 3-bit byte counter (0..4) SHALL select the TX byte; after bytes 0..3, the FSM SHALL enter BYTE_GAP for BYTE_GAP_CYC cycles with o_sclk=0, then return to SHIFT.
REQ-025 After byte 4, the FSM SHALL enter CS_HOLD for CS_HOLD_CYC cycles with o_cs=0, then DONE.
REQ-026 DONE SHALL last one cycle, with o_cs=1, o_busy=0 and o_done=1, then return to IDLE.
REQ-027 o_x and o_y SHALL update atomically in DONE only: o_x={rx1[1:0],rx0}, o_y={rx3[1:0],rx2}, o_btn=rx4[1:0]; they SHALL hold otherwise.
REQ-028 Received bytes SHALL be stored in a 40-bit shift register; partial data SHALL never reach the outputs.
REQ-029 All delay counters SHALL be wide enough for their parameter value and reload to zero on every state entry.
REQ-030 i_start asserted in the DONE cycle SHALL be ignored; a new transaction needs i_start while in IDLE.

Reset
REQ-031 i_n_reset=0 SHALL immediately force state IDLE, o_cs=1, o_sclk=0, o_mosi=0, o_busy=0, o_done=0, o_x=0, o_y=0, o_btn=0, and clear all counters.
REQ-032 Reset mid-transaction SHALL abort it without a done pulse and leave the outputs at their reset values.

Verification (CLK_DIV=2, CS_SETUP_CYC=6, BYTE_GAP_CYC=4, CS_HOLD_CYC=3)
REQ-033 i_cmd=0x84 and i_param=0x11223344, with the slave model returning 0x34,0x02,0xC8,0x01,0x03 -> MOSI bytes 84,11,22,33,44; o_x=0x234; o_y=0x1C8; o_btn=2'b11; one o_done pulse.
REQ-034 Timing check with one start -> exactly 2+6+5*32+4*4+3 cycles, with o_cs low for 185 cycles and exactly 40 SCLK rising edges.
REQ-035 i_start pulsed repeatedly during SHIFT -> no restart, and exactly one o_done.
REQ-036 i_n_reset pulled low during byte 2 -> o_cs=1 and o_sclk=0 asynchronously, o_done stays 0, and previous o_x/o_y are cleared to 0.
REQ-037 Back-to-back transactions with i_start held high -> a new transaction begins on the cycle after DONE returns to IDLE, and the second result replaces the first.

Source files
------------

// File: rtl/jstk2_spi_sequencer.sv
// SPI master for the JSTK2 joystick: sends one command byte plus four parameter
// bytes (mode 0, MSB-first) and publishes the decoded position/buttons atomically.
module jstk2_spi_sequencer #(
    parameter int unsigned CLK_DIV      = 100,
    parameter int unsigned CS_SETUP_CYC = 1500,
    parameter int unsigned BYTE_GAP_CYC = 1000,
    parameter int unsigned CS_HOLD_CYC  = 100
) (
    input  logic        i_clk,
    input  logic        i_n_reset,
    input  logic        i_start,
    input  logic [7:0]  i_cmd,
    input  logic [31:0] i_param,
    input  logic        i_miso,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_cs,
    output logic        o_busy,
    output logic        o_done,
    output logic [9:0]  o_x,
    output logic [9:0]  o_y,
    output logic [1:0]  o_btn
);

    localparam int unsigned BIT_CYC   = 2 * CLK_DIV;
    localparam int unsigned MAX_A     = (CS_SETUP_CYC > BYTE_GAP_CYC) ? CS_SETUP_CYC : BYTE_GAP_CYC;
    localparam int unsigned MAX_B     = (CS_HOLD_CYC > BIT_CYC) ? CS_HOLD_CYC : BIT_CYC;
    localparam int unsigned MAX_CYC   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W     = $clog2(MAX_CYC + 1);
    localparam int unsigned FRAME_W   = 40;
    localparam int unsigned LAST_BYTE = 4;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        BYTE_GAP,
        CS_HOLD,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [2:0]           byte_q, byte_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [FRAME_W-1:0]   rx_q, rx_d;
    logic                 sclk_d, mosi_d, cs_d, busy_d, done_d;
    logic [9:0]           x_d, y_d;
    logic [1:0]           btn_d;

    // Next-state, datapath and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        x_d     = o_x;
        y_d     = o_y;
        btn_d   = o_btn;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    tx_d    = {i_cmd, i_param};
                    rx_d    = '0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SHIFT: begin
                // MISO is captured on the same edge that raises SCLK
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    rx_d = {rx_q[FRAME_W-2:0], i_miso};
                end
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
                        if (byte_q == 3'(LAST_BYTE)) begin
                            state_d = CS_HOLD;
                        end else begin
                            byte_d  = byte_q + 3'd1;
                            state_d = BYTE_GAP;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYTE_GAP: begin
                // MOSI holds the previous bit through the gap and advances with the next low phase
                if (cnt_q == CNT_W'(BYTE_GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    tx_d    = {tx_q[FRAME_W-2:0], 1'b0};
                    state_d = SHIFT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CS_HOLD: begin
                if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
                    cnt_d   = '0;
                    x_d     = {rx_q[25:24], rx_q[39:32]};
                    y_d     = {rx_q[9:8], rx_q[23:16]};
                    btn_d   = rx_q[1:0];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CS_SETUP) || (state_d == SHIFT) ||
                 (state_d == BYTE_GAP) || (state_d == CS_HOLD);
        cs_d   = !busy_d;
        done_d = (state_d == DONE);
        sclk_d = (state_d == SHIFT) && (cnt_d >= CNT_W'(CLK_DIV));
        mosi_d = busy_d && tx_d[FRAME_W-1];
    end

    // State, datapath and output registers.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            o_sclk  <= 1'b0;
            o_mosi  <= 1'b0;
            o_cs    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_x     <= '0;
            o_y     <= '0;
            o_btn   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            o_sclk  <= sclk_d;
            o_mosi  <= mosi_d;
            o_cs    <= cs_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
            o_x     <= x_d;
            o_y     <= y_d;
            o_btn   <= btn_d;
        end
    end

endmodule

// File: tb/tb_jstk2_spi_sequencer.sv
// Randomized bench for jstk2_spi_sequencer: a slave model plays back response
// frames and a transaction-level model predicts MOSI bytes, timing and decoded outputs.
module tb_jstk2_spi_sequencer;

    localparam int unsigned CLK_DIV      = 2;
    localparam int unsigned CS_SETUP_CYC = 6;
    localparam int unsigned BYTE_GAP_CYC = 4;
    localparam int unsigned CS_HOLD_CYC  = 3;
    // Chip select stays low for setup, 5 bytes of 8 bits, 4 gaps and the hold time.
    localparam int unsigned TXN_CS_LOW   = CS_SETUP_CYC + 5 * 8 * 2 * CLK_DIV + 4 * BYTE_GAP_CYC + CS_HOLD_CYC;
    // Samples from the start request to the done pulse (start cycle + CS-low span).
    localparam int unsigned TXN_LAT      = TXN_CS_LOW + 1;

    logic        i_clk;
    logic        i_n_reset;
    logic        i_start;
    logic [7:0]  i_cmd;
    logic [31:0] i_param;
    logic        i_miso;
    logic        o_sclk, o_mosi, o_cs, o_busy, o_done;
    logic [9:0]  o_x, o_y;
    logic [1:0]  o_btn;

    jstk2_spi_sequencer #(
        .CLK_DIV      (CLK_DIV),
        .CS_SETUP_CYC (CS_SETUP_CYC),
        .BYTE_GAP_CYC (BYTE_GAP_CYC),
        .CS_HOLD_CYC  (CS_HOLD_CYC)
    ) dut (
        .i_clk     (i_clk),
        .i_n_reset (i_n_reset),
        .i_start   (i_start),
        .i_cmd     (i_cmd),
        .i_param   (i_param),
        .i_miso    (i_miso),
        .o_sclk    (o_sclk),
        .o_mosi    (o_mosi),
        .o_cs      (o_cs),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_x       (o_x),
        .o_y       (o_y),
        .o_btn     (o_btn)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [39:0] slave_q[$];
    logic [39:0] cur_slave = '0;
    int          rises = 0;
    int          cs_low = 0;
    logic [39:0] mosi_cap = '0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [39:0] last_mosi = '0;
    int          last_rises = 0;
    int          last_cs_low = 0;
    int          bad_updates = 0;
    logic [21:0] prev_out = '0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] model_x(input logic [39:0] s);
        return 10'((int'(s[31:24]) % 4) * 256 + int'(s[39:32]));
    endfunction

    function automatic logic [9:0] model_y(input logic [39:0] s);
        return 10'((int'(s[15:8]) % 4) * 256 + int'(s[23:16]));
    endfunction

    function automatic logic [1:0] model_btn(input logic [39:0] s);
        return 2'(int'(s[7:0]) % 4);
    endfunction

    // One clock of observation: slave playback, MOSI capture and bookkeeping.
    task automatic tick();
        @(negedge i_clk);
        cyc++;
        if (!o_cs && prev_cs) begin
            cur_slave = (slave_q.size() > 0) ? slave_q.pop_front() : 40'h0;
            rises     = 0;
            cs_low    = 0;
            mosi_cap  = '0;
        end
        if (!o_cs) cs_low++;
        if (o_sclk && !prev_sclk) begin
            rises++;
            mosi_cap = {mosi_cap[38:0], o_mosi};
        end
        if (!o_sclk) i_miso = (rises < 40) ? cur_slave[39 - rises] : 1'b0;
        if (o_done) begin
            done_cnt++;
            done_cyc    = cyc;
            last_mosi   = mosi_cap;
            last_rises  = rises;
            last_cs_low = cs_low;
        end
        if (i_n_reset && !o_done && ({o_x, o_y, o_btn} != prev_out)) bad_updates++;
        prev_out  = {o_x, o_y, o_btn};
        prev_cs   = o_cs;
        prev_sclk = o_sclk;
    endtask

    task automatic check_result(input string tag, input logic [7:0] cmd, input logic [31:0] param,
                                input logic [39:0] slave);
        expect_eq({tag, " mosi"}, 64'(last_mosi), 64'({cmd, param}));
        expect_eq({tag, " rises"}, 64'(last_rises), 64'd40);
        expect_eq({tag, " cs_low"}, 64'(last_cs_low), 64'(TXN_CS_LOW));
        expect_eq({tag, " x"}, 64'(o_x), 64'(model_x(slave)));
        expect_eq({tag, " y"}, 64'(o_y), 64'(model_y(slave)));
        expect_eq({tag, " btn"}, 64'(o_btn), 64'(model_btn(slave)));
        expect_eq({tag, " cs_in_done"}, 64'(o_cs), 64'd1);
        expect_eq({tag, " busy_in_done"}, 64'(o_busy), 64'd0);
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [31:0] param, input logic [39:0] slave,
                           input bit pulse, input string tag);
        int c0;
        int d0;
        int n;
        slave_q.push_back(slave);
        i_cmd   = cmd;
        i_param = param;
        d0      = done_cnt;
        c0      = cyc;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            i_cmd   = 8'($urandom);
            i_param = $urandom;
            if (pulse) i_start = (rises >= 1 && rises <= 38) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            n++;
        end
        i_start = 1'b0;
        expect_eq({tag, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
        expect_eq({tag, " latency"}, 64'(done_cyc - c0), 64'(TXN_LAT));
        check_result(tag, cmd, param, slave);
        repeat (8) tick();
        expect_eq({tag, " no_restart"}, 64'(done_cnt - d0), 64'd1);
        expect_eq({tag, " cs_idle"}, 64'(o_cs), 64'd1);
    endtask

    initial begin
        logic [39:0] sa;
        logic [39:0] sb;
        logic [7:0]  ca;
        logic [7:0]  cb;
        logic [31:0] pa;
        logic [31:0] pb;
        int          d0;
        int          n;
        int          first_done;

        i_n_reset = 1'b0;
        i_start   = 1'b0;
        i_cmd     = '0;
        i_param   = '0;
        i_miso    = 1'b0;
        repeat (3) tick();
        expect_eq("rst cs", 64'(o_cs), 64'd1);
        expect_eq("rst sclk", 64'(o_sclk), 64'd0);
        expect_eq("rst mosi", 64'(o_mosi), 64'd0);
        expect_eq("rst busy", 64'(o_busy), 64'd0);
        expect_eq("rst done", 64'(o_done), 64'd0);
        expect_eq("rst xyb", 64'({o_x, o_y, o_btn}), 64'd0);
        i_n_reset = 1'b1;
        repeat (3) tick();
        expect_eq("idle cs", 64'(o_cs), 64'd1);

        // Reference transaction with known slave data.
        run_txn(8'h84, 32'h11223344, 40'h34_02_C8_01_03, 1'b0, "dir");
        expect_eq("dir x_const", 64'(o_x), 64'h234);
        expect_eq("dir y_const", 64'(o_y), 64'h1C8);
        expect_eq("dir btn_const", 64'(o_btn), 64'h3);

        for (int i = 0; i < 6; i++) begin
            run_txn(8'($urandom), $urandom, {$urandom, 8'($urandom)}, (i % 2) == 1, $sformatf("rnd%0d", i));
        end

        // Abort during byte 2 with SCLK high; outputs must clear asynchronously.
        sa = {$urandom, 8'($urandom)} | 40'h01_00_00_00_00;
        run_txn(8'h5A, $urandom, sa, 1'b0, "pre_rst");
        expect_eq("pre_rst x_held", 64'(o_x), 64'(model_x(sa)));
        slave_q.push_back({$urandom, 8'($urandom)});
        i_cmd   = 8'hC3;
        i_param = $urandom;
        d0      = done_cnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        while (!(rises >= 19 && o_sclk) && n < 1000) begin
            tick();
            n++;
        end
        expect_eq("mid_rst reached_byte2", 64'(rises >= 17 && rises <= 24 && o_sclk), 64'd1);
        #2 i_n_reset = 1'b0;
        #1;
        expect_eq("mid_rst cs", 64'(o_cs), 64'd1);
        expect_eq("mid_rst sclk", 64'(o_sclk), 64'd0);
        expect_eq("mid_rst busy", 64'(o_busy), 64'd0);
        expect_eq("mid_rst done", 64'(o_done), 64'd0);
        expect_eq("mid_rst xyb", 64'({o_x, o_y, o_btn}), 64'd0);
        repeat (3) tick();
        i_n_reset = 1'b1;
        repeat (250) tick();
        expect_eq("post_rst no_done", 64'(done_cnt - d0), 64'd0);
        expect_eq("post_rst cs", 64'(o_cs), 64'd1);
        expect_eq("post_rst xyb", 64'({o_x, o_y, o_btn}), 64'd0);

        // Back-to-back with i_start held high.
        ca = 8'($urandom); pa = $urandom; sa = {$urandom, 8'($urandom)};
        cb = 8'($urandom); pb = $urandom; sb = {$urandom, 8'($urandom)};
        slave_q.push_back(sa);
        slave_q.push_back(sb);
        i_cmd   = ca;
        i_param = pa;
        d0      = done_cnt;
        i_start = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 1000) begin
            tick();
            n++;
        end
        i_cmd   = cb;
        i_param = pb;
        first_done = done_cyc;
        expect_eq("b2b first_done", 64'(done_cnt - d0), 64'd1);
        check_result("b2b_a", ca, pa, sa);
        n = 0;
        while (done_cnt == d0 + 1 && n < 1000) begin
            tick();
            n++;
        end
        i_start = 1'b0;
        expect_eq("b2b second_done", 64'(done_cnt - d0), 64'd2);
        expect_eq("b2b spacing", 64'(done_cyc - first_done), 64'(TXN_LAT + 1));
        check_result("b2b_b", cb, pb, sb);
        repeat (10) tick();
        expect_eq("b2b no_third", 64'(done_cnt - d0), 64'd2);

        expect_eq("outputs_only_in_done", 64'(bad_updates), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
